// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions used by the memory responder and its response
// buffer.
//   - tl_a_op_e  : Channel A request opcodes handled here (Get, PutFullData,
//                  PutPartialData).
//   - tl_d_op_e  : Channel D response opcodes (AccessAck, AccessAckData).
//   - tl_d_rsp_t : one complete Channel D beat, as stored in the buffer.
// The struct field widths are the default widths of the responder.
package tlul_pkg;

  localparam int TL_DW  = 32;  // data width
  localparam int TL_SZW = 3;   // size field width
  localparam int TL_AIW = 2;   // source id width
  localparam int TL_DIW = 1;   // sink id width
  localparam int TL_PW  = 3;   // param width

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    tl_d_op_e          opcode;
    logic [TL_PW-1:0]  param;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic [TL_DIW-1:0] sink;
    logic [TL_DW-1:0]  data;
    logic              error;
  } tl_d_rsp_t;

endpackage

// File: rtl/tlul_resp_fifo.sv
// Two-entry response buffer holding complete Channel D beats.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the buffer)
//   push       : write wdata (accepted when not full, or full with a pop)
//   wdata      : response beat to store
//   pop        : release the head entry (ignored when empty)
//   rdata      : head entry, valid whenever empty = 0
//   full/empty : occupancy flags
module tlul_resp_fifo
  import tlul_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  tl_d_rsp_t wdata,
  input  logic      pop,
  output tl_d_rsp_t rdata,
  output logic      full,
  output logic      empty
);

  tl_d_rsp_t  mem_p1 [2];
  logic       wptr;
  logic       rptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop & ~empty;
  // A pop frees the slot the same edge, so a push into a full buffer is legal.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only; occupancy is tracked by the reset counters.
  always_ff @(posedge clk) begin
    if (do_push) mem_p1[wptr] <= wdata;
  end

  assign rdata = mem_p1[rptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/tlul_mem_responder.sv
// TL-UL memory responder: decodes Channel A requests, checks them for
// errors, reads/writes a word-organised backing store and queues the
// Channel D response in a two-entry buffer (one-cycle latency when empty).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   a_valid/a_ready       : Channel A handshake
//   a_opcode .. a_data    : Channel A request fields
//   d_valid/d_ready       : Channel D handshake
//   d_opcode .. d_error   : Channel D response fields (all 0 when idle)
module tlul_mem_responder
  import tlul_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    SRC_WIDTH    = 2,
  parameter int                    SINK_WIDTH   = 1,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter int                    MEM_WORDS    = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int OFF_W = $clog2(MASK_WIDTH);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(4 * MEM_WORDS);

  // Byte lanes covered by an access of 2^size bytes starting at lane lo.
  function automatic logic [MASK_WIDTH-1:0] lane_mask(
    input logic [SIZE_WIDTH-1:0] size,
    input logic [OFF_W-1:0]      lo
  );
    logic [MASK_WIDTH-1:0] m;
    int first;
    int last;
    first = int'(lo);
    last  = first + (1 << int'(size));
    m     = '0;
    for (int i = 0; i < MASK_WIDTH; i++) m[i] = (i >= first) && (i < last);
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [OFF_W-1:0] align_mask(input logic [SIZE_WIDTH-1:0] size);
    return OFF_W'((1 << int'(size)) - 1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  ready_en;
  logic                  vld_p0;
  logic                  fifo_full;
  logic                  fifo_empty;
  tl_d_rsp_t             rsp_p0;
  tl_d_rsp_t             head_p1;
  tl_d_rsp_t             d_rsp;
  logic [ADDR_WIDTH:0]   off;
  logic [IDX_W-1:0]      idx;
  logic                  is_get;
  logic                  is_put;
  logic                  err;
  logic                  size_err;
  logic                  unused_a_param;

  assign unused_a_param = ^a_param;

  // Holds a_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign a_ready = ready_en & ~fifo_full;
  assign vld_p0  = a_valid & a_ready;

  // ---- stage p0: decode and error check of the Channel A beat ----
  // Extra MSB on the offset turns an address below BASE_ADDR into a huge
  // value, so one compare covers both ends of the window.
  assign off = {1'b0, a_address} - {1'b0, BASE_ADDR};
  assign idx = off[IDX_W+1:2];

  always_comb begin
    is_get   = (a_opcode == Get);
    is_put   = (a_opcode == PutFullData) || (a_opcode == PutPartialData);
    size_err = (a_size > SIZE_WIDTH'(2));
    err      = 1'b0;
    if (!(is_get || is_put)) err = 1'b1;
    if (off >= SPAN)         err = 1'b1;
    if (size_err)            err = 1'b1;
    if (a_mask == '0)        err = 1'b1;
    if (!size_err && ((a_address[OFF_W-1:0] & align_mask(a_size)) != '0)) err = 1'b1;
    if (!size_err && (a_opcode == PutFullData) &&
        (a_mask != lane_mask(a_size, a_address[OFF_W-1:0]))) err = 1'b1;

    rsp_p0        = '0;
    rsp_p0.opcode = is_get ? AccessAckData : AccessAck;
    rsp_p0.size   = a_size;
    rsp_p0.source = a_source;
    rsp_p0.error  = err;
    rsp_p0.data   = (is_get && !err) ? mem[idx] : '0;
  end

  // Byte-lane write on the handshake edge; erroneous requests never write.
  always_ff @(posedge clk) begin
    if (vld_p0 && is_put && !err) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  // ---- stage p1: buffered response presented on Channel D ----
  tlul_resp_fifo u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_p0),
    .wdata (rsp_p0),
    .pop   (d_ready),
    .rdata (head_p1),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign d_valid  = ~fifo_empty;
  assign d_rsp    = fifo_empty ? '0 : head_p1;
  assign d_opcode = d_rsp.opcode;
  assign d_param  = d_rsp.param;
  assign d_size   = d_rsp.size;
  assign d_source = d_rsp.source;
  assign d_sink   = d_rsp.sink;
  assign d_data   = d_rsp.data;
  assign d_error  = d_rsp.error;

endmodule

// File: tb/tb_tlul_mem_responder.sv
module tb_tlul_mem_responder;

  localparam logic [2:0] OP_PF  = 3'd0;
  localparam logic [2:0] OP_PP  = 3'd1;
  localparam logic [2:0] OP_GET = 3'd4;
  localparam logic [2:0] OP_AA  = 3'd0;
  localparam logic [2:0] OP_AAD = 3'd1;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  src;
    logic        sink;
    logic [31:0] data;
    logic        err;
  } d_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [2:0]  size;
    logic [1:0]  src;
    d_t          e;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [2:0]  a_size = '0;
  logic [1:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [2:0]  d_size;
  logic [1:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_error;

  d_t exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tlul_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error)
  );

  function automatic d_t mk(input logic [2:0] op, input logic [2:0] size,
                            input logic [1:0] src, input logic [31:0] data, input logic err);
    d_t r;
    r.op = op; r.param = 3'd0; r.size = size; r.src = src;
    r.sink = 1'b0; r.data = data; r.err = err;
    return r;
  endfunction

  function automatic stim_t st(input logic [2:0] op, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data,
                               input logic [2:0] size, input logic [1:0] src, input d_t e);
    stim_t s;
    s.op = op; s.addr = addr; s.mask = mask; s.data = data;
    s.size = size; s.src = src; s.e = e;
    return s;
  endfunction

  function automatic d_t d_now();
    d_t r;
    r.op = d_opcode; r.param = d_param; r.size = d_size; r.src = d_source;
    r.sink = d_sink; r.data = d_data; r.err = d_error;
    return r;
  endfunction

  // Drives one request, records its expected response, returns after the
  // handshake edge (+1) with a_valid low; ok = 0 if a_ready never came.
  task automatic send(input stim_t s, output bit ok);
    exp_q.push_back(s.e);
    a_valid = 1'b1; a_opcode = s.op; a_address = s.addr; a_mask = s.mask;
    a_data = s.data; a_size = s.size; a_source = s.src;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic recv(output d_t got, output bit ok);
    d_ready = 1'b1; ok = 1'b0; got = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (d_valid) begin got = d_now(); ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    d_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    total++;
    if ({d_valid, d_now()} !== '0) begin
      bad++; $display("FAIL reset_d_outputs got=%b_%h exp=all-zero", d_valid, d_now());
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if (a_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b exp=0", a_ready); end
    @(posedge clk); #1;
    total++;
    if (a_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b exp=1", a_ready); end
    total++;
    if (d_valid !== 1'b0) begin bad++; $display("FAIL idle_d_valid got=%b exp=0", d_valid); end
  endtask

  task automatic test_put_get();
    stim_t s[2];
    d_t got, e;
    bit ok1, ok2;
    s[0] = st(OP_PF,  32'h10, 4'hF, 32'hDEADBEEF, 3'd2, 2'd1, mk(OP_AA, 3'd2, 2'd1, 32'h0, 1'b0));
    s[1] = st(OP_GET, 32'h10, 4'hF, 32'h0,        3'd2, 2'd2, mk(OP_AAD, 3'd2, 2'd2, 32'hDEADBEEF, 1'b0));
    for (int i = 0; i < 2; i++) begin
      send(s[i], ok1);
      total++;
      if (!ok1 || d_valid !== 1'b1) begin
        bad++; $display("FAIL put_get_latency%0d got=%b exp=1 accepted=%b", i, d_valid, ok1);
      end
      recv(got, ok2);
      e = exp_q.pop_front();
      total++;
      if (!ok2 || got !== e) begin bad++; $display("FAIL put_get_rsp%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_partial();
    stim_t s[2];
    d_t got, e;
    bit ok1, ok2;
    s[0] = st(OP_PP,  32'h10, 4'h2, 32'h0000AA00, 3'd2, 2'd3, mk(OP_AA, 3'd2, 2'd3, 32'h0, 1'b0));
    s[1] = st(OP_GET, 32'h10, 4'hF, 32'h0,        3'd2, 2'd0, mk(OP_AAD, 3'd2, 2'd0, 32'hDEADAAEF, 1'b0));
    for (int i = 0; i < 2; i++) begin
      send(s[i], ok1);
      recv(got, ok2);
      e = exp_q.pop_front();
      total++;
      if (!ok1 || !ok2 || got !== e) begin bad++; $display("FAIL partial_rsp%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  // Put followed by a Get on the very next cycle, both buffered before draining.
  task automatic test_put_then_get();
    stim_t s[4];
    d_t got, e;
    bit ok1, ok2, ok3;
    s[0] = st(OP_PF,  32'h20,  4'hF, 32'h11223344, 3'd2, 2'd1, mk(OP_AA, 3'd2, 2'd1, 32'h0, 1'b0));
    s[1] = st(OP_GET, 32'h20,  4'hF, 32'h0,        3'd2, 2'd2, mk(OP_AAD, 3'd2, 2'd2, 32'h11223344, 1'b0));
    s[2] = st(OP_PF,  32'h3FC, 4'hF, 32'hA5A55A5A, 3'd2, 2'd0, mk(OP_AA, 3'd2, 2'd0, 32'h0, 1'b0));
    s[3] = st(OP_GET, 32'h3FC, 4'hF, 32'h0,        3'd2, 2'd3, mk(OP_AAD, 3'd2, 2'd3, 32'hA5A55A5A, 1'b0));
    for (int p = 0; p < 4; p += 2) begin
      send(s[p], ok1);
      send(s[p+1], ok2);
      for (int k = 0; k < 2; k++) begin
        recv(got, ok3);
        e = exp_q.pop_front();
        total++;
        if (!ok1 || !ok2 || !ok3 || got !== e) begin
          bad++; $display("FAIL put_then_get%0d got=%h exp=%h", p + k, got, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[3];
    d_t got[3];
    d_t e;
    bit ok1, ok2, acc;
    int n;
    s[0] = st(OP_GET, 32'h10,  4'hF, 32'h0, 3'd2, 2'd0, mk(OP_AAD, 3'd2, 2'd0, 32'hDEADAAEF, 1'b0));
    s[1] = st(OP_GET, 32'h20,  4'hF, 32'h0, 3'd2, 2'd1, mk(OP_AAD, 3'd2, 2'd1, 32'h11223344, 1'b0));
    s[2] = st(OP_GET, 32'h3FC, 4'hF, 32'h0, 3'd2, 2'd3, mk(OP_AAD, 3'd2, 2'd3, 32'hA5A55A5A, 1'b0));
    d_ready = 1'b0;
    send(s[0], ok1);
    send(s[1], ok2);
    exp_q.push_back(s[2].e);
    a_valid = 1'b1; a_opcode = s[2].op; a_address = s[2].addr; a_mask = s[2].mask;
    a_data = s[2].data; a_size = s[2].size; a_source = s[2].src;
    repeat (3) @(negedge clk);
    total++;
    if (!ok1 || !ok2 || a_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_stall got=%b exp=0 accepted=%b%b", a_ready, ok1, ok2);
    end
    total++;
    if (d_now() !== exp_q[0] || d_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_hold got=%h exp=%h", d_now(), exp_q[0]);
    end
    @(posedge clk); #1;
    d_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      acc = a_valid && a_ready;
      if (d_valid) begin got[n] = d_now(); n++; end
      @(posedge clk); #1;
      if (acc) a_valid = 1'b0;
    end
    d_ready = 1'b0;
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      total++;
      if (i >= n || got[i] !== e) begin
        bad++; $display("FAIL b2b_order%0d got=%h exp=%h seen=%0d", i, got[i], e, n);
      end
    end
  endtask

  task automatic test_errors();
    stim_t s[13];
    d_t got, e;
    bit ok1, ok2;
    s[0]  = st(OP_GET, 32'h400, 4'hF, 32'h0,        3'd2, 2'd1, mk(OP_AAD, 3'd2, 2'd1, 32'h0, 1'b1));
    s[1]  = st(OP_GET, 32'h002, 4'hF, 32'h0,        3'd2, 2'd2, mk(OP_AAD, 3'd2, 2'd2, 32'h0, 1'b1));
    s[2]  = st(3'd3,   32'h010, 4'hF, 32'h55,       3'd2, 2'd0, mk(OP_AA,  3'd2, 2'd0, 32'h0, 1'b1));
    s[3]  = st(OP_PF,  32'h010, 4'h7, 32'hFFFFFFFF, 3'd2, 2'd3, mk(OP_AA,  3'd2, 2'd3, 32'h0, 1'b1));
    s[4]  = st(OP_GET, 32'h010, 4'hF, 32'h0,        3'd2, 2'd0, mk(OP_AAD, 3'd2, 2'd0, 32'hDEADAAEF, 1'b0));
    s[5]  = st(OP_GET, 32'h010, 4'h0, 32'h0,        3'd2, 2'd1, mk(OP_AAD, 3'd2, 2'd1, 32'h0, 1'b1));
    s[6]  = st(OP_GET, 32'h010, 4'hF, 32'h0,        3'd3, 2'd2, mk(OP_AAD, 3'd3, 2'd2, 32'h0, 1'b1));
    s[7]  = st(OP_PF,  32'h011, 4'h2, 32'h00007700, 3'd0, 2'd3, mk(OP_AA,  3'd0, 2'd3, 32'h0, 1'b0));
    s[8]  = st(OP_PF,  32'h011, 4'h1, 32'h000000FF, 3'd0, 2'd0, mk(OP_AA,  3'd0, 2'd0, 32'h0, 1'b1));
    s[9]  = st(OP_GET, 32'h010, 4'hF, 32'h0,        3'd2, 2'd1, mk(OP_AAD, 3'd2, 2'd1, 32'hDEAD77EF, 1'b0));
    s[10] = st(OP_PP,  32'h3FE, 4'hC, 32'h0,        3'd1, 2'd2, mk(OP_AA,  3'd1, 2'd2, 32'h0, 1'b0));
    s[11] = st(OP_GET, 32'h3FC, 4'hF, 32'h0,        3'd2, 2'd3, mk(OP_AAD, 3'd2, 2'd3, 32'h00005A5A, 1'b0));
    s[12] = st(OP_GET, 32'h3FD, 4'h6, 32'h0,        3'd1, 2'd0, mk(OP_AAD, 3'd1, 2'd0, 32'h0, 1'b1));
    for (int i = 0; i < 13; i++) begin
      send(s[i], ok1);
      recv(got, ok2);
      e = exp_q.pop_front();
      total++;
      if (!ok1 || !ok2 || got !== e) begin bad++; $display("FAIL err_step%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[4];
    d_t got, e;
    bit ok1, ok2;
    s[0] = st(OP_PF,  32'h30, 4'hF, 32'hCAFEF00D, 3'd2, 2'd1, mk(OP_AA,  3'd2, 2'd1, 32'h0, 1'b0));
    s[1] = st(OP_GET, 32'h30, 4'hF, 32'h0,        3'd2, 2'd2, mk(OP_AAD, 3'd2, 2'd2, 32'hCAFEF00D, 1'b0));
    s[2] = st(OP_GET, 32'h30, 4'hF, 32'h0,        3'd2, 2'd3, mk(OP_AAD, 3'd2, 2'd3, 32'hCAFEF00D, 1'b0));
    s[3] = st(OP_GET, 32'h10, 4'hF, 32'h0,        3'd2, 2'd0, mk(OP_AAD, 3'd2, 2'd0, 32'hDEAD77EF, 1'b0));
    send(s[0], ok1);
    recv(got, ok2);
    e = exp_q.pop_front();
    total++;
    if (!ok1 || !ok2 || got !== e) begin bad++; $display("FAIL rstmid_put got=%h exp=%h", got, e); end
    d_ready = 1'b0;
    send(s[1], ok1);
    total++;
    if (!ok1 || d_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pending got=%b exp=1", d_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({d_valid, a_ready, d_now()} !== '0) begin
      bad++; $display("FAIL rstmid_drop got=%b%b_%h exp=all-zero", d_valid, a_ready, d_now());
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 2; i < 4; i++) begin
      send(s[i], ok1);
      recv(got, ok2);
      e = exp_q.pop_front();
      total++;
      if (!ok1 || !ok2 || got !== e) begin bad++; $display("FAIL rstmid_keep%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_put_then_get();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
